vga_update_scheduler: RTL and testbench
=======================================

// Module: vga_update_scheduler
// PURPOSE
//  Schedules snake game-state updates against the VGA raster. Watches the
//  sync_gen pixel position and ready strobe. Issues one update request to the
//  game logic every (speed+1) frames, at the start of vertical blanking, so
//  state never changes mid-frame. Flags updates that run into the next active
//  frame and asks the colour/render stage to hold.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line (col_addr range 0..H_ACTIVE-1)
//  V_ACTIVE  720   active lines per frame (row_addr range 0..V_ACTIVE-1)
//  SPEED_W   4     width of speed input
//  FCNT_W    16    width of frame_cnt / tick_cnt
// PORTS
//  clk         in   1        pixel clock (74.25 MHz for 720p)
//  rst         in   1        synchronous reset, active-high
//  ready       in   1        sync_gen active-video strobe
//  col_addr    in   11       sync_gen current column
//  row_addr    in   11       sync_gen current row
//  speed       in   SPEED_W  frames between updates minus 1 (0 = every frame)
//  pause       in   1        1 = freeze divider, no new requests
//  upd_ack     in   1        game logic: update finished (1-cycle pulse)
//  clr_ovr     in   1        clear sticky overrun flag
//  upd_req     out  1        update request, level, held until upd_ack
//  render_hold out  1        1 while an update overlaps active video
//  overrun     out  1        sticky: update late or tick dropped
//  frame_cnt   out  FCNT_W   frames seen (wraps)
//  tick_cnt    out  FCNT_W   update requests issued (wraps)
// BEHAVIOUR
//  - Reset: state=IDLE, div_cnt=0; upd_req, render_hold, overrun=0;
//    frame_cnt=0, tick_cnt=0. Reset mid-request drops the request at once.
//  - vb_start  = ready & row_addr==V_ACTIVE-1 & col_addr==H_ACTIVE-1.
//  - act_start = ready & row_addr==0 & col_addr==0.
//  - frame_cnt +1 on every vb_start, pause or not; wraps to 0.
//  - Divider: on vb_start & !pause:
//    - if div_cnt>=speed: div_cnt<=0, tick=1.
//    - else div_cnt<=div_cnt+1.
//    Compare is >=, so lowering speed below div_cnt fires on the next vb_start.
//  - FSM (all outputs registered, visible the cycle after the cause):
//    - IDLE: upd_req=0. On tick -> REQ; tick_cnt+1. upd_ack ignored.
//    - REQ:  upd_req=1.
//      - upd_ack -> IDLE.
//      - act_start & !upd_ack -> LATE, overrun<=1.
//      - upd_ack & act_start in the same cycle -> IDLE, no overrun.
//    - LATE: upd_req=1, render_hold=1. upd_ack -> IDLE.
//  - Latency: vb_start cycle N -> upd_req high N+1.
//    upd_ack cycle M -> upd_req low M+1.
//  - Tick while in REQ/LATE: tick dropped, tick_cnt unchanged, overrun<=1.
//  - overrun: set has priority over clr_ovr in the same cycle; otherwise
//    clr_ovr clears it.
//  - pause: divider holds. An in-flight request completes normally.
//    Deasserting pause resumes counting from the held div_cnt.
//  - Counters are plain unsigned wrap-around; no saturation.
// TESTING (sim with H_ACTIVE=8, V_ACTIVE=4, blanking per sync_gen model)
//  1 speed=0, ack 3 cycles after req -> upd_req rises 1 cycle after every
//    vb_start, low 1 cycle after ack; tick_cnt=frame_cnt=5 after 5 frames;
//    overrun=0.
//  2 speed=2 -> requests after frames 3,6,9; tick_cnt=3 after 9 frames.
//    speed 3->0 with div_cnt=2 -> tick at the next vb_start.
//  3 no ack through next act_start -> render_hold=1 and overrun=1 one cycle
//    after act_start; ack -> upd_req=0, render_hold=0; overrun stays 1 until
//    clr_ovr.
//  4 ack coincident with act_start -> IDLE, overrun=0.
//    Tick while busy -> overrun=1, tick_cnt unchanged.
//  5 pause=1 for 4 frames -> no req, frame_cnt +4, div_cnt frozen.
//    Pause during REQ -> ack still returns to IDLE.
//  6 rst=1 in LATE -> next cycle all outputs 0, state IDLE.
//    Counters wrap FFFF->0000 (force FCNT_W=4: 15->0).

Source files
------------

// File: rtl/vga_update_scheduler.sv
// Paces snake game-state updates to the VGA raster.
// Requests an update at vertical-blank start every (speed+1) frames and
// raises render_hold when an update is still running into active video.
//
// Ports:
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   i_ready             sync_gen active-video strobe
//   i_col_addr/row_addr sync_gen raster position
//   i_speed             frames between updates minus one
//   i_pause             freeze the frame divider
//   i_upd_ack           game logic finished the update (pulse)
//   i_clr_ovr           clear the sticky overrun flag
//   o_upd_req           update request, held until acknowledged
//   o_render_hold       update overlaps active video
//   o_overrun           sticky: update ran late or a tick was dropped
//   o_frame_cnt         frames seen (wraps)
//   o_tick_cnt          update requests issued (wraps)
module vga_update_scheduler #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int SPEED_W  = 4,
    parameter int FCNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ready,
    input  logic [10:0]       i_col_addr,
    input  logic [10:0]       i_row_addr,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic              i_pause,
    input  logic              i_upd_ack,
    input  logic              i_clr_ovr,
    output logic              o_upd_req,
    output logic              o_render_hold,
    output logic              o_overrun,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic [FCNT_W-1:0] o_tick_cnt
);

    localparam logic [10:0] LP_H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] LP_V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [FCNT_W-1:0] LP_F_ONE = FCNT_W'(1);
    localparam logic [SPEED_W-1:0] LP_D_ONE = SPEED_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LATE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [SPEED_W-1:0]  r_div_cnt;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic [FCNT_W-1:0]   r_tick_cnt;
    logic                r_upd_req;
    logic                r_render_hold;
    logic                r_overrun;

    logic w_vb_start;
    logic w_act_start;
    logic w_tick;
    logic w_set_ovr;
    logic w_tick_inc;

    // Last active pixel of the frame marks the start of vertical blanking.
    assign w_vb_start  = i_ready && (i_row_addr == LP_V_LAST)
                         && (i_col_addr == LP_H_LAST);
    assign w_act_start = i_ready && (i_row_addr == 11'd0)
                         && (i_col_addr == 11'd0);

    // >= so that lowering speed below the current count fires promptly.
    assign w_tick = w_vb_start && !i_pause && (r_div_cnt >= i_speed);

    always_comb begin
        w_state_nx = r_state;
        w_set_ovr  = 1'b0;
        w_tick_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nx = S_REQ;
                    w_tick_inc = 1'b1;
                end
            end
            S_REQ: begin
                // Ack wins over a coincident frame start: no overrun.
                if (i_upd_ack) begin
                    w_state_nx = S_IDLE;
                end else if (w_act_start) begin
                    w_state_nx = S_LATE;
                    w_set_ovr  = 1'b1;
                end
                if (w_tick) begin
                    w_set_ovr = 1'b1;
                end
            end
            S_LATE: begin
                if (i_upd_ack) begin
                    w_state_nx = S_IDLE;
                end
                if (w_tick) begin
                    w_set_ovr = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_tick_cnt    <= '0;
            r_upd_req     <= 1'b0;
            r_render_hold <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_upd_req     <= (w_state_nx != S_IDLE);
            r_render_hold <= (w_state_nx == S_LATE);

            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end

            if (w_vb_start) begin
                r_frame_cnt <= r_frame_cnt + LP_F_ONE;
            end

            if (w_tick_inc) begin
                r_tick_cnt <= r_tick_cnt + LP_F_ONE;
            end

            if (w_vb_start && !i_pause) begin
                if (r_div_cnt >= i_speed) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + LP_D_ONE;
                end
            end
        end
    end

    assign o_upd_req     = r_upd_req;
    assign o_render_hold = r_render_hold;
    assign o_overrun     = r_overrun;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_tick_cnt    = r_tick_cnt;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// Directed bench for vga_update_scheduler on a tiny 8x4 raster
// (10x6 total) with 4-bit counters so wrap-around is reachable.
module tb_vga_update_scheduler;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [10:0] col;
    logic [10:0] row;
    logic [3:0]  speed;
    logic        pause;
    logic        ack;
    logic        clr;
    logic        upd_req;
    logic        hold;
    logic        ovr;
    logic [3:0]  frame_cnt;
    logic [3:0]  tick_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_frame = 0;
    int exp_tick = 0;

    vga_update_scheduler #(
        .H_ACTIVE(8),
        .V_ACTIVE(4),
        .SPEED_W (4),
        .FCNT_W  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ready      (ready),
        .i_col_addr   (col),
        .i_row_addr   (row),
        .i_speed      (speed),
        .i_pause      (pause),
        .i_upd_ack    (ack),
        .i_clr_ovr    (clr),
        .o_upd_req    (upd_req),
        .o_render_hold(hold),
        .o_overrun    (ovr),
        .o_frame_cnt  (frame_cnt),
        .o_tick_cnt   (tick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: outputs settle at +1, then the raster moves on.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (col == 11'd9) begin
            col = 11'd0;
            row = (row == 11'd5) ? 11'd0 : row + 11'd1;
        end else begin
            col = col + 11'd1;
        end
        ready = (col < 11'd8) && (row < 11'd4);
    endtask

    // Advance until the raster inputs sit at (r,c) ahead of the next edge.
    task automatic go_to(input int r, input int c);
        int n;
        n = 0;
        while ((row != 11'(r) || col != 11'(c)) && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL goto_timeout row=%0d col=%0d", r, c);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_frame"}, 32'(frame_cnt), 32'(exp_frame % 16));
        chk({tag, "_tick"}, 32'(tick_cnt), 32'(exp_tick % 16));
    endtask

    // One vblank; optionally ack the request after 'dly' extra cycles.
    task automatic frame_step(input bit exp_req, input int dly,
                              input string tag);
        go_to(3, 7);
        cyc();
        exp_frame++;
        chk({tag, "_req"}, 32'(upd_req), 32'(exp_req));
        if (exp_req) begin
            exp_tick++;
            repeat (dly) cyc();
            ack = 1'b1;
            cyc();
            ack = 1'b0;
            chk({tag, "_ackdrop"}, 32'(upd_req), 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        speed = 4'd0;
        pause = 1'b0;
        ack   = 1'b0;
        clr   = 1'b0;
        row   = 11'd4;
        col   = 11'd0;
        ready = 1'b0;
        repeat (3) cyc();
        chk("rst_req", 32'(upd_req), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk_cnt("rst");
        rst = 1'b0;

        // every-frame updates, ack three cycles after request
        for (int i = 0; i < 5; i++) frame_step(1'b1, 2, "t1");
        chk_cnt("t1");
        chk("t1_ovr", 32'(ovr), 32'd0);

        // speed 2: request on every third frame
        speed = 4'd2;
        for (int k = 1; k <= 9; k++) frame_step((k % 3) == 0, 1, "t2");
        chk_cnt("t2");
        speed = 4'd3;
        frame_step(1'b0, 1, "t2_s3a");
        frame_step(1'b0, 1, "t2_s3b");
        speed = 4'd0;
        frame_step(1'b1, 1, "t2_s0");
        chk_cnt("t2_lower");

        // late update runs into active video
        go_to(3, 7);
        cyc();
        exp_frame++;
        exp_tick++;
        chk("t3_req", 32'(upd_req), 32'd1);
        go_to(0, 0);
        cyc();
        chk("t3_hold", 32'(hold), 32'd1);
        chk("t3_ovr", 32'(ovr), 32'd1);
        chk("t3_req_late", 32'(upd_req), 32'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t3_req_off", 32'(upd_req), 32'd0);
        chk("t3_hold_off", 32'(hold), 32'd0);
        chk("t3_ovr_sticky", 32'(ovr), 32'd1);
        repeat (5) cyc();
        chk("t3_ovr_keep", 32'(ovr), 32'd1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t3_ovr_clr", 32'(ovr), 32'd0);

        // ack coincident with frame start: no overrun
        go_to(3, 7);
        cyc();
        exp_frame++;
        exp_tick++;
        chk("t4_req", 32'(upd_req), 32'd1);
        go_to(0, 0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t4_coinc_req", 32'(upd_req), 32'd0);
        chk("t4_coinc_ovr", 32'(ovr), 32'd0);
        chk("t4_coinc_hold", 32'(hold), 32'd0);

        // tick arriving while still busy is dropped
        go_to(3, 7);
        cyc();
        exp_frame++;
        exp_tick++;
        chk("t4b_req", 32'(upd_req), 32'd1);
        go_to(0, 0);
        cyc();
        chk("t4b_late_ovr", 32'(ovr), 32'd1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t4b_clr", 32'(ovr), 32'd0);
        go_to(3, 7);
        cyc();
        exp_frame++;
        chk("t4b_drop_ovr", 32'(ovr), 32'd1);
        chk("t4b_drop_req", 32'(upd_req), 32'd1);
        chk_cnt("t4b_drop");
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t4b_ack", 32'(upd_req), 32'd0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t4b_clr2", 32'(ovr), 32'd0);

        // pause freezes the divider at 1
        speed = 4'd2;
        frame_step(1'b0, 1, "t5_pre");
        pause = 1'b1;
        for (int i = 0; i < 4; i++) frame_step(1'b0, 1, "t5_pause");
        chk_cnt("t5_pause");
        pause = 1'b0;
        frame_step(1'b0, 1, "t5_res1");
        frame_step(1'b1, 1, "t5_res2");
        chk_cnt("t5_resume");

        // pause does not block an in-flight request
        speed = 4'd0;
        go_to(3, 7);
        cyc();
        exp_frame++;
        exp_tick++;
        chk("t5_inflight", 32'(upd_req), 32'd1);
        pause = 1'b1;
        repeat (2) cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t5_paused_ack", 32'(upd_req), 32'd0);
        pause = 1'b0;

        // reset while LATE
        go_to(3, 7);
        cyc();
        go_to(0, 0);
        cyc();
        chk("t6_hold", 32'(hold), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_frame = 0;
        exp_tick = 0;
        chk("t6_req", 32'(upd_req), 32'd0);
        chk("t6_hold0", 32'(hold), 32'd0);
        chk("t6_ovr", 32'(ovr), 32'd0);
        chk_cnt("t6_rst");
        frame_step(1'b1, 1, "t6_idle");

        // counter wrap 15 -> 0
        for (int i = 0; i < 14; i++) frame_step(1'b1, 1, "t6_run");
        chk_cnt("t6_fifteen");
        frame_step(1'b1, 1, "t6_wrap");
        chk("t6_wrap_frame", 32'(frame_cnt), 32'd0);
        chk("t6_wrap_tick", 32'(tick_cnt), 32'd0);
        chk("t6_wrap_ovr", 32'(ovr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
